// File: rtl/interrupt_gateway_bank_pkg.sv
// rtl/interrupt_gateway_bank_pkg.sv - shared types and constants for the interrupt gateway bank
package interrupt_gateway_bank_pkg;

    typedef enum logic [1:0] {
        GW_IDLE   = 2'd0,
        GW_PEND   = 2'd1,
        GW_FLIGHT = 2'd2
    } gw_state_e;

    localparam int CNT_W   = 2;
    localparam int ID_NONE = 0;

endpackage

// File: rtl/interrupt_gateway.sv
// rtl/interrupt_gateway.sv - single-source gateway: IDLE/PEND/FLIGHT with optional edge counting
module interrupt_gateway
    import interrupt_gateway_bank_pkg::*;
#(
    parameter bit IS_EDGE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_int,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_pending
);

    gw_state_e        r_state;
    gw_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_prev;
    logic             w_rise;
    logic             w_cnt_max;

    assign w_rise    = IS_EDGE && i_int && !r_prev;
    assign w_cnt_max = &r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= GW_IDLE;
            r_cnt   <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_prev  <= i_int;
        end
    end

    // An edge coinciding with a completion that consumes a counted edge leaves the count unchanged.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            GW_IDLE: begin
                if (IS_EDGE ? w_rise : i_int) w_state_nxt = GW_PEND;
            end
            GW_PEND: begin
                if (i_claim) w_state_nxt = GW_FLIGHT;
                if (w_rise && !w_cnt_max) w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            GW_FLIGHT: begin
                if (i_complete) begin
                    if (!IS_EDGE) begin
                        w_state_nxt = i_int ? GW_PEND : GW_IDLE;
                    end else if (r_cnt != '0) begin
                        w_state_nxt = GW_PEND;
                        if (!w_rise) w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_state_nxt = w_rise ? GW_PEND : GW_IDLE;
                    end
                end else if (w_rise && !w_cnt_max) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = GW_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_pending = (r_state == GW_PEND);
    end

endmodule

// File: rtl/interrupt_gateway_bank.sv
// rtl/interrupt_gateway_bank.sv - bank of per-source gateways with claim/complete decode and priority select
module interrupt_gateway_bank
    import interrupt_gateway_bank_pkg::*;
#(
    parameter int                 NUM_SRC   = 8,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
    localparam int                ID_W      = $clog2(NUM_SRC + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] int_sync,
    input  logic               claim_valid,
    input  logic [ID_W-1:0]    claim_id,
    input  logic               complete_valid,
    input  logic [ID_W-1:0]    complete_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               top_valid,
    output logic [ID_W-1:0]    top_id
);

    logic [NUM_SRC-1:0] w_claim_hit;
    logic [NUM_SRC-1:0] w_complete_hit;

    // IDs 0 and above NUM_SRC never match any slot, so they fall through as no-ops.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        localparam logic [ID_W-1:0] SRC_ID = ID_W'(g + 1);

        assign w_claim_hit[g]    = claim_valid && (claim_id == SRC_ID);
        assign w_complete_hit[g] = complete_valid && (complete_id == SRC_ID);

        interrupt_gateway #(
            .IS_EDGE (EDGE_MASK[g])
        ) u_gw (
            .clock      (clock),
            .reset      (reset),
            .i_int      (int_sync[g]),
            .i_claim    (w_claim_hit[g]),
            .i_complete (w_complete_hit[g]),
            .o_pending  (pending[g])
        );
    end

    assign top_valid = |pending;

    always_comb begin
        top_id = ID_W'(ID_NONE);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) top_id = ID_W'(i + 1);
        end
    end

endmodule

// File: tb/tb_interrupt_gateway_bank.sv
// tb/tb_interrupt_gateway_bank.sv - directed scoreboard bench for interrupt_gateway_bank
module tb_interrupt_gateway_bank;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] int_sync = '0;
    logic       claim_valid = 1'b0;
    logic [3:0] claim_id = '0;
    logic       complete_valid = 1'b0;
    logic [3:0] complete_id = '0;
    logic [7:0] pending;
    logic       top_valid;
    logic [3:0] top_id;

    interrupt_gateway_bank #(
        .NUM_SRC   (8),
        .EDGE_MASK (8'h01)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .int_sync       (int_sync),
        .claim_valid    (claim_valid),
        .claim_id       (claim_id),
        .complete_valid (complete_valid),
        .complete_id    (complete_id),
        .pending        (pending),
        .top_valid      (top_valid),
        .top_id         (top_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        int         tag;
        logic [7:0] p;
        logic [3:0] id;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc   = 0;
    int   tag   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            m_e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL step%0d missed: expected sample at cycle %0d, now %0d", m_e.tag, m_e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            m_e = q.pop_front();
            tests++;
            if (pending !== m_e.p || top_id !== m_e.id || top_valid !== (m_e.p != 8'h00)) begin
                fails++;
                $display("FAIL step%0d: pending=%h top_valid=%b top_id=%0d, required pending=%h top_valid=%b top_id=%0d",
                         m_e.tag, pending, top_valid, top_id, m_e.p, (m_e.p != 8'h00), m_e.id);
            end
        end
    end

    task automatic step(input logic rst, input logic [7:0] in,
                        input logic cv, input logic [3:0] cid,
                        input logic pv, input logic [3:0] pid,
                        input logic [7:0] ep, input logic [3:0] eid);
        exp_t e;
        @(posedge clock);
        #1;
        reset          = rst;
        int_sync       = in;
        claim_valid    = cv;
        claim_id       = cid;
        complete_valid = pv;
        complete_id    = pid;
        tag++;
        e.cyc = cyc + 1;
        e.tag = tag;
        e.p   = ep;
        e.id  = eid;
        q.push_back(e);
    endtask

    initial begin
        // reset state
        step(1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        step(1, 8'h04, 0, 0, 0, 0, 8'h00, 0);

        // level source 3: pend, claim, complete while still high, retire
        step(0, 8'h04, 0, 0, 0, 0, 8'h04, 3);
        step(0, 8'h04, 1, 3, 0, 0, 8'h00, 0);
        step(0, 8'h04, 0, 0, 1, 3, 8'h04, 3);
        step(0, 8'h00, 1, 3, 0, 0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1, 3, 8'h00, 0);
        step(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

        // sources 5 and 2: priority, no retraction, invalid claims
        step(0, 8'h12, 0, 0, 0, 0, 8'h12, 2);
        step(0, 8'h00, 1, 2, 0, 0, 8'h10, 5);
        step(0, 8'h00, 1, 0, 0, 0, 8'h10, 5);
        step(0, 8'h00, 1, 9, 0, 0, 8'h10, 5);
        step(0, 8'h00, 1, 2, 0, 0, 8'h10, 5);
        step(0, 8'h00, 0, 0, 1, 2, 8'h10, 5);
        step(0, 8'h00, 1, 5, 0, 0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1, 5, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1, 5, 8'h00, 0);

        // same-cycle claim+complete to source 4: only the claim lands
        step(0, 8'h08, 0, 0, 0, 0, 8'h08, 4);
        step(0, 8'h00, 1, 4, 1, 4, 8'h00, 0);
        step(0, 8'h08, 0, 0, 0, 0, 8'h00, 0);
        step(0, 8'h08, 0, 0, 1, 4, 8'h08, 4);
        step(0, 8'h00, 1, 4, 0, 0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1, 4, 8'h00, 0);

        // claim 6 and complete 3 in the same cycle both land
        step(0, 8'h24, 0, 0, 0, 0, 8'h24, 3);
        step(0, 8'h00, 1, 3, 0, 0, 8'h20, 6);
        step(0, 8'h00, 1, 6, 1, 3, 8'h00, 0);
        step(0, 8'h04, 0, 0, 1, 6, 8'h04, 3);
        step(0, 8'h00, 1, 3, 0, 0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1, 3, 8'h00, 0);

        // edge source 1: five pulses, four grants, then idle
        step(0, 8'h01, 0, 0, 0, 0, 8'h01, 1);
        for (int k = 0; k < 4; k++) begin
            step(0, 8'h00, 0, 0, 0, 0, 8'h01, 1);
            step(0, 8'h01, 0, 0, 0, 0, 8'h01, 1);
        end
        step(0, 8'h00, 0, 0, 0, 0, 8'h01, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
            step(0, 8'h00, 0, 0, 1, 1, 8'h01, 1);
        end
        step(0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1, 1, 8'h00, 0);
        step(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

        // completion with count 0 coinciding with a new edge: one more grant only
        step(0, 8'h01, 0, 0, 0, 0, 8'h01, 1);
        step(0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
        step(0, 8'h01, 0, 0, 1, 1, 8'h01, 1);
        step(0, 8'h01, 1, 1, 0, 0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1, 1, 8'h00, 0);
        step(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

        // completion with count 1 coinciding with a new edge: count stays 1
        step(0, 8'h01, 0, 0, 0, 0, 8'h01, 1);
        step(0, 8'h00, 0, 0, 0, 0, 8'h01, 1);
        step(0, 8'h01, 0, 0, 0, 0, 8'h01, 1);
        step(0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
        step(0, 8'h01, 0, 0, 1, 1, 8'h01, 1);
        step(0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1, 1, 8'h01, 1);
        step(0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1, 1, 8'h00, 0);

        // reset mid-service discards FLIGHT; later completion ignored
        step(0, 8'h01, 0, 0, 0, 0, 8'h01, 1);
        step(0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
        step(1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1, 1, 8'h00, 0);
        step(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

        // held-high edge input registers one edge right after reset
        step(1, 8'h01, 0, 0, 0, 0, 8'h00, 0);
        step(0, 8'h01, 0, 0, 0, 0, 8'h01, 1);
        step(0, 8'h01, 1, 1, 0, 0, 8'h00, 0);
        step(0, 8'h01, 0, 0, 1, 1, 8'h00, 0);
        step(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

        repeat (3) @(posedge clock);
        #1;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected samples left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
